// File: rtl/wb_stage_pipe.sv
// Y86-64 write-back stage: W register feeds regfile ports E/M; results visible one cycle after capture.
// stall_i or a latched non-AOK status holds W; optional retired counter under WB_RETIRE_CNT_EN.
module wb_stage_pipe #(
  parameter int                 DATA_W  = 64,
  parameter int                 RADDR_W = 4,
  parameter logic [RADDR_W-1:0] RNONE   = {RADDR_W{1'b1}},
  parameter int                 CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic               stall_i,
  input  logic               bubble_i,
  input  logic [3:0]         icode_i,
  input  logic               cnd_i,
  input  logic [RADDR_W-1:0] dst_e_i,
  input  logic [RADDR_W-1:0] dst_m_i,
  input  logic [DATA_W-1:0]  valE_i,
  input  logic [DATA_W-1:0]  valM_i,
  input  logic               instr_valid_i,
  input  logic               imem_error_i,
  input  logic               dmem_error_i,
  output logic               we_e_o,
  output logic [RADDR_W-1:0] dst_e_o,
  output logic [DATA_W-1:0]  valE_o,
  output logic               we_m_o,
  output logic [RADDR_W-1:0] dst_m_o,
  output logic [DATA_W-1:0]  valM_o,
  output logic [1:0]         stat_o,
  output logic               halted_o
`ifdef WB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] retired_o
`endif
);

  localparam logic [1:0] ST_AOK = 2'b00;
  localparam logic [1:0] ST_HLT = 2'b01;
  localparam logic [1:0] ST_ADR = 2'b10;
  localparam logic [1:0] ST_INS = 2'b11;
  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;

  typedef struct packed {
    logic               wv;
    logic [3:0]         icode;
    logic [RADDR_W-1:0] dst_e;
    logic [RADDR_W-1:0] dst_m;
    logic [DATA_W-1:0]  val_e;
    logic [DATA_W-1:0]  val_m;
    logic [1:0]         st;
  } w_t;

  localparam w_t W_BUBBLE = '{wv: 1'b0, icode: I_NOP, dst_e: RNONE, dst_m: RNONE,
                              val_e: '0, val_m: '0, st: ST_AOK};

  w_t         w_q;
  w_t         w_in;
  logic       halted_q;
  logic [1:0] sticky_q;
  logic       w_hold;

  assign w_hold = halted_q || stall_i;

  always_comb begin
    w_in       = W_BUBBLE;
    w_in.wv    = 1'b1;
    w_in.icode = icode_i;
    w_in.dst_e = (icode_i == I_CMOV && !cnd_i) ? RNONE : dst_e_i;
    w_in.dst_m = dst_m_i;
    w_in.val_e = valE_i;
    w_in.val_m = valM_i;
    // Fetch faults outrank decode faults, which outrank memory faults and halt.
    if (imem_error_i)        w_in.st = ST_ADR;
    else if (!instr_valid_i) w_in.st = ST_INS;
    else if (dmem_error_i)   w_in.st = ST_ADR;
    else if (icode_i == I_HALT) w_in.st = ST_HLT;
    else                     w_in.st = ST_AOK;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q      <= W_BUBBLE;
      halted_q <= 1'b0;
      sticky_q <= ST_AOK;
    end else begin
      if (!halted_q && w_q.wv && w_q.st != ST_AOK) begin
        halted_q <= 1'b1;
        sticky_q <= w_q.st;
      end
      if (w_hold)                     w_q <= w_q;
      else if (bubble_i || !valid_i)  w_q <= W_BUBBLE;
      else                            w_q <= w_in;
    end
  end

  // Port M priority on equal addresses is resolved inside the register file.
  assign we_e_o   = w_q.wv && w_q.st == ST_AOK && w_q.dst_e != RNONE;
  assign we_m_o   = w_q.wv && w_q.st == ST_AOK && w_q.dst_m != RNONE;
  assign dst_e_o  = w_q.dst_e;
  assign dst_m_o  = w_q.dst_m;
  assign valE_o   = w_q.val_e;
  assign valM_o   = w_q.val_m;
  assign halted_o = halted_q;
  assign stat_o   = halted_q ? sticky_q : (w_q.wv ? w_q.st : ST_AOK);

  logic unused_icode;
  assign unused_icode = ^{w_q.icode, ST_INS};

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      retired_q <= '0;
    else if (!w_hold && w_q.wv && w_q.st == ST_AOK)
      retired_q <= retired_q + 1'b1;
  end

  assign retired_o = retired_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Registered Y86-64 write-back stage with a parametrised datapath.
- Captures memory-stage results into a W pipeline register and drives the register-file write ports (E and M) from that register.
- Computes prioritised CPU status and latches it sticky once a non-AOK instruction retires.
- Exposes W-register contents for forwarding and supports stall/bubble control from the hazard unit.

Parameters:
- DATA_W, 64, width of valE/valM and register-file write data.
- RADDR_W, 4, register-specifier width.
- RNONE, 4'hF, register specifier meaning "no destination".
- CNT_W, 32, retired-instruction counter width (optional feature only).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- valid_i  input  1  memory stage presents an instruction this cycle.
- stall_i  input  1  hold W register contents.
- bubble_i  input  1  load a NOP bubble into W register.
- icode_i  input  4  instruction code.
- cnd_i  input  1  condition result (cmovXX).
- dst_e_i  input  RADDR_W  E destination.
- dst_m_i  input  RADDR_W  M destination.
- valE_i  input  DATA_W  ALU result.
- valM_i  input  DATA_W  memory read data.
- instr_valid_i  input  1  instruction decoded as valid.
- imem_error_i  input  1  fetch address error.
- dmem_error_i  input  1  data memory address error.
- we_e_o  output  1  register write enable, port E.
- dst_e_o  output  RADDR_W  port E address; also forwarding W_dstE.
- valE_o  output  DATA_W  port E data; also forwarding W_valE.
- we_m_o  output  1  register write enable, port M.
- dst_m_o  output  RADDR_W  port M address; also forwarding W_dstM.
- valM_o  output  DATA_W  port M data; also forwarding W_valM.
- stat_o  output  2  CPU status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- halted_o  output  1  sticky: status is non-AOK, pipeline must freeze.
- retired_o  output  CNT_W  retired count (optional feature only).

Behaviour:
- W register fields: wv, icode, dstE, dstM, valE, valM, st.
- Update priority on each rising edge:
  - rst_i: clear to bubble (wv=0, icode=NOP 4'h1, dstE=dstM=RNONE, valE=valM=0, st=AOK). Also clear the sticky status and the counter.
  - else halted_o=1: W holds. Stall and bubble are ignored.
  - else stall_i: W holds. stall_i wins over bubble_i when both are asserted.
  - else bubble_i or !valid_i: load bubble.
  - else: capture the inputs.
- Capture rules:
  - dstE = (icode_i==4'h2 && !cnd_i) ? RNONE : dst_e_i. A cmov that is not taken writes nothing.
  - st, first match wins: imem_error_i -> ADR; !instr_valid_i -> INS; dmem_error_i -> ADR; icode_i==4'h0 -> HLT; else AOK.
- Write enables, derived combinationally from W:
  - we_e_o = wv && st==AOK && dstE!=RNONE.
  - we_m_o likewise, using dstM.
  - A faulting or halting instruction never writes the register file.
  - When dstE==dstM and both enables are set, both assert. The register file gives port M priority, so the popl %rsp case is handled there.
- stat_o:
  - Equals the sticky status if halted_o=1, else W.st when wv=1, else AOK. Bubbles report AOK.
- Sticky status:
  - Set on the edge after W holds wv=1 with st!=AOK. Latches that st and sets halted_o.
  - Only rst_i clears it.
- Latency:
  - An instruction accepted at edge N drives the write ports and stat_o during cycle N+1, i.e. register file write at edge N+1.
- Reset outputs: we_e_o=we_m_o=0, dst_e_o=dst_m_o=RNONE, valE_o=valM_o=0, stat_o=00, halted_o=0, retired_o=0.
- Reset asserted mid-stall or while halted: the next edge clears everything.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - retired_o counts edges where W has wv=1 and st==AOK, and W is leaving (not stalled, not halted).
  - Wraps modulo 2^CNT_W.
  - Cleared by rst_i.
- Undefined:
  - retired_o port is absent and no counter logic is built.

Test Plan:
- Ordinary capture: irmovq with dst_e_i=3, valE_i=64'h1234, valid_i=1. Next cycle: we_e_o=1, dst_e_o=3, valE_o=64'h1234, we_m_o=0, stat_o=00.
- Cmov not taken: icode 2, cnd_i=0, dst_e_i=5 -> dst_e_o=F, we_e_o=0. Repeat with cnd_i=1 -> we_e_o=1.
- Stall/bubble: hold stall_i=1 for 3 cycles after an mrmovq (dst_m_i=7, valM_i=64'hAA). Outputs stay constant. Then assert stall_i=1 and bubble_i=1 together -> W holds. Then bubble_i=1 alone -> we_e_o=we_m_o=0.
- Status priority:
  - imem_error_i=1 with dmem_error_i=1 -> stat_o=10.
  - instr_valid_i=0 alone -> 11.
  - Both enables 0 in each case.
- Halt sticky: retire icode 0. stat_o=01 and halted_o=1 the following cycle. Further valid inputs are ignored and stat_o stays 01 until rst_i pulses, after which stat_o=00.
- WB_RETIRE_CNT_EN: five valid AOK instructions, one bubble, one stalled cycle -> retired_o=5. With CNT_W=3, nine retirements -> retired_o=1.
